// File: rtl/ncl_serial_add_ctrl.sv
// Bit-serial controller around a single dual-rail NCL full adder: walks the
// operands LSB first, alternating DATA and NULL wavefronts, with a phase timeout.
//   state | meaning
//   IDLE  | waiting for operands (adder must be NULL-closed first)
//   DATA  | presenting bit i as DATA, waiting for adder closure
//   NULL  | presenting NULL, waiting for adder to reopen
//   DONE  | result held until the consumer takes it
module ncl_serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int TMO   = 64
) (
    input  logic             clk,
    input  logic             init,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic [1:0]       fa_a,
    output logic [1:0]       fa_b,
    output logic [1:0]       fa_cin,
    input  logic [1:0]       fa_sum,
    input  logic [1:0]       fa_cout,
    output logic             fa_sum_ack,
    output logic             fa_carry_ack,
    input  logic             fa_comp
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {IDLE, DATA, NULL, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             carry_q, carry_d, err_q, err_d;
    logic [IW-1:0]    i_q, i_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             comp_meta_q, comp_meta_d, fa_comp_s_q, fa_comp_s_d;
    logic             out_valid_q, out_valid_d, out_cout_q, out_cout_d, out_err_q, out_err_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;

    function automatic logic [1:0] dual_rail(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    function automatic logic one_hot(input logic [1:0] x);
        return (x == 2'b01) || (x == 2'b10);
    endfunction

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        s_d          = s_q;
        carry_d      = carry_q;
        err_d        = err_q;
        i_d          = i_q;
        cnt_d        = cnt_q;
        comp_meta_d  = fa_comp;
        fa_comp_s_d  = comp_meta_q;
        out_sum_d    = out_sum_q;
        out_cout_d   = out_cout_q;
        out_err_d    = out_err_q;
        in_ready     = 1'b0;
        fa_a         = 2'b00;
        fa_b         = 2'b00;
        fa_cin       = 2'b00;
        fa_sum_ack   = 1'b1;
        fa_carry_ack = 1'b1;

        case (state_q)
            IDLE: begin
                in_ready = !fa_comp_s_q;
                if (in_valid && !fa_comp_s_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    s_d     = '0;
                    i_d     = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                fa_a         = dual_rail(a_q[i_q]);
                fa_b         = dual_rail(b_q[i_q]);
                fa_cin       = dual_rail(carry_q);
                fa_sum_ack   = 1'b0;
                fa_carry_ack = 1'b0;
                cnt_d        = cnt_q + CW'(1);
                if (fa_comp_s_q) begin
                    // Illegal encodings are flagged but the rail[1] value is still used.
                    s_d[i_q] = fa_sum[1];
                    carry_d  = fa_cout[1];
                    if (!one_hot(fa_sum) || !one_hot(fa_cout))
                        err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = NULL;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            NULL: begin
                cnt_d = cnt_q + CW'(1);
                if (!fa_comp_s_q) begin
                    cnt_d = '0;
                    if (i_q == IW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        i_d     = i_q + IW'(1);
                        state_d = DATA;
                    end
                end else if (cnt_q == CW'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        if (state_q != DONE && state_d == DONE) begin
            out_sum_d  = s_d;
            out_cout_d = carry_d;
            out_err_d  = err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            carry_q     <= 1'b0;
            err_q       <= 1'b0;
            i_q         <= '0;
            cnt_q       <= '0;
            comp_meta_q <= 1'b0;
            fa_comp_s_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            s_q         <= s_d;
            carry_q     <= carry_d;
            err_q       <= err_d;
            i_q         <= i_d;
            cnt_q       <= cnt_d;
            comp_meta_q <= comp_meta_d;
            fa_comp_s_q <= fa_comp_s_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_cout  = out_cout_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_ncl_serial_add_ctrl.sv
// Directed bench for ncl_serial_add_ctrl with a zero-delay behavioural NCL full
// adder that can be made to stall closure or emit an illegal sum code.
module tb_ncl_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       init, in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, out_err;
    logic [7:0] in_a, in_b, out_sum;
    logic [1:0] fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic       fa_sum_ack, fa_carry_ack, fa_comp;
    logic       stall, bad_sum;
    int         checks = 0;
    int         errors = 0;
    int         n;
    int         seen;

    always #5 clk = ~clk;

    ncl_serial_add_ctrl #(.WIDTH(8), .TMO(64)) dut (
        .clk(clk), .init(init), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .out_err(out_err),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
        .fa_sum_ack(fa_sum_ack), .fa_carry_ack(fa_carry_ack), .fa_comp(fa_comp)
    );

    function automatic logic [1:0] dr(input logic v);
        return v ? 2'b10 : 2'b01;
    endfunction

    function automatic logic oh(input logic [1:0] x);
        return (x == 2'b01) || (x == 2'b10);
    endfunction

    // Zero-delay adder: DATA out only when all inputs are DATA, NULL otherwise.
    always_comb begin
        fa_sum  = 2'b00;
        fa_cout = 2'b00;
        fa_comp = 1'b0;
        if (oh(fa_a) && oh(fa_b) && oh(fa_cin)) begin
            fa_sum  = bad_sum ? 2'b11 : dr(fa_a[1] ^ fa_b[1] ^ fa_cin[1]);
            fa_cout = dr((fa_a[1] & fa_b[1]) | (fa_a[1] & fa_cin[1]) | (fa_b[1] & fa_cin[1]));
            fa_comp = !stall;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cnt);
        repeat (cnt) @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic c);
        int w;
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            tick(1);
            w++;
        end
        check("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 300) begin
            tick(1);
            cyc++;
        end
        check(tag, out_valid, 1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        init = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; stall = 1'b0; bad_sum = 1'b0;
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_err", out_err, 0);
        check("rst_fa_a", fa_a, 2'b00);
        check("rst_sack", fa_sum_ack, 1);
        check("rst_cack", fa_carry_ack, 1);
        init = 1'b0;
        tick(1);
        check("idle_ready", in_ready, 1);

        // 35 + 4A
        accept(8'h35, 8'h4A, 1'b0);
        check("t1_in_ready_busy", in_ready, 0);
        wait_valid("t1_valid", n);
        check("t1_latency", n, 48);
        check("t1_sum", out_sum, 8'h7F);
        check("t1_cout", out_cout, 0);
        check("t1_err", out_err, 0);
        take_result();
        check("t1_ready_after", in_ready, 1);

        // FF + 01: carry ripples through every bit
        accept(8'hFF, 8'h01, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("t2_fa_cin", fa_cin, (k == 0) ? 2'b01 : 2'b10);
            check("t2_fa_a", fa_a, 2'b10);
            check("t2_fa_b", fa_b, (k == 0) ? 2'b10 : 2'b01);
            check("t2_data_ack", fa_sum_ack, 0);
            tick(3);
            check("t2_null_cin", fa_cin, 2'b00);
            check("t2_null_ack", fa_carry_ack, 1);
            tick(3);
        end
        wait_valid("t2_valid", n);
        check("t2_latency", n, 0);
        check("t2_sum", out_sum, 8'h00);
        check("t2_cout", out_cout, 1);
        take_result();

        // FF + FF + 1 with consumer back-pressure
        accept(8'hFF, 8'hFF, 1'b1);
        wait_valid("t3_valid", n);
        check("t3_latency", n, 48);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_sum", out_sum, 8'hFF);
            check("t3_hold_cout", out_cout, 1);
            check("t3_hold_ready", in_ready, 0);
        end
        take_result();

        // F6 + 03 + 1 with closure stalled on bit 3 DATA
        accept(8'hF6, 8'h03, 1'b1);
        tick(17);
        stall = 1'b1;
        wait_valid("t4_valid", n);
        check("t4_latency", n + 17, 82);
        check("t4_sum", out_sum, 8'h02);
        check("t4_cout", out_cout, 1);
        check("t4_err", out_err, 1);
        stall = 1'b0;
        take_result();

        // 01 + 01 with illegal sum code on bit 0
        bad_sum = 1'b1;
        accept(8'h01, 8'h01, 1'b0);
        tick(4);
        bad_sum = 1'b0;
        wait_valid("t5_valid", n);
        check("t5_sum", out_sum, 8'h03);
        check("t5_cout", out_cout, 0);
        check("t5_err", out_err, 1);
        take_result();

        // init during bit 5 NULL, then a clean transaction
        accept(8'h35, 8'h4A, 1'b0);
        tick(34);
        check("t6_in_null", fa_a, 2'b00);
        init = 1'b1;
        tick(1);
        init = 1'b0;
        check("t6_abort_valid", out_valid, 0);
        check("t6_abort_ready", in_ready, 1);
        check("t6_abort_ack", fa_sum_ack, 1);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            tick(1);
            if (out_valid) seen++;
        end
        check("t6_no_valid", seen, 0);
        accept(8'h01, 8'h01, 1'b0);
        wait_valid("t6_valid", n);
        check("t6_latency", n, 48);
        check("t6_sum", out_sum, 8'h02);
        check("t6_cout", out_cout, 0);
        check("t6_err", out_err, 0);
        take_result();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ncl_serial_add_ctrl.md
NCL_SERIAL_ADD_CTRL -- requirements
Module: ncl_serial_add_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  WIDTH  8   operand width in bits
  TMO    64  max clocks waiting in one wavefront phase before abort
REQ-002 Ports (name  direction  width  meaning) SHALL be:
  clk          in   1      sole clock, rising edge
  init         in   1      reset, synchronous, active-high
  in_valid     in   1      operand request
  in_ready     out  1      controller can accept operands
  in_a         in   WIDTH  operand A
  in_b         in   WIDTH  operand B
  in_cin       in   1      carry-in
  out_valid    out  1      result available
  out_ready    in   1      result consumer accepts
  out_sum      out  WIDTH  sum
  out_cout     out  1      final carry-out
  out_err      out  1      encoding error or timeout occurred
  fa_a         out  2      dual-rail A to full adder
  fa_b         out  2      dual-rail B to full adder
  fa_cin       out  2      dual-rail carry-in to full adder
  fa_sum       in   2      dual-rail sum from full adder
  fa_cout      in   2      dual-rail carry-out from full adder
  fa_sum_ack   out  1      sum completion to adder: 0 request-DATA, 1 request-NULL
  fa_carry_ack out  1      carry completion to adder: same encoding
  fa_comp      in   1      adder closure, asynchronous: 1 outputs DATA, 0 outputs NULL
REQ-003 Dual-rail encoding SHALL be: 2'b10 = logic 1, 2'b01 = logic 0, 2'b00 = NULL, 2'b11 = illegal.

Function
REQ-004 fa_comp SHALL pass through a 2-flop synchronizer (fa_comp_s) before any use; no other fa_* input is synchronized.
REQ-005 FSM states SHALL be IDLE, DATA, NULL, DONE.
REQ-006 IDLE: in_ready = 1 only when fa_comp_s == 0; in_valid && in_ready latches in_a, in_b, in_cin into internal A, B, carry register, clears bit index i = 0 and err, and moves to DATA.
REQ-007 DATA: fa_a/fa_b/fa_cin SHALL drive dual-rail A[i], B[i], carry; both acks = 0; on fa_comp_s == 1, sample fa_sum into S[i] and fa_cout into carry (rail[1]), then move to NULL.
REQ-008 At the DATA sample, fa_sum or fa_cout not exactly one-hot SHALL set err (sticky per transaction); S[i] and carry still take rail[1]; sequencing continues.
REQ-009 NULL: fa_a/fa_b/fa_cin = 2'b00; both acks = 1; on fa_comp_s == 0, if i == WIDTH-1 go to DONE, else i = i+1 and go to DATA.
REQ-010 In every state other than DATA/NULL, fa_a/fa_b/fa_cin = 2'b00 and both acks = 1.
REQ-011 A phase counter SHALL clear on each DATA/NULL entry and increment each cycle in that state; reaching TMO SHALL set err and go directly to DONE. Unprocessed S bits stay 0, and out_cout takes the current carry register.
REQ-012 DONE: out_valid = 1; out_sum = S, out_cout = carry, out_err = err held stable; on out_ready, go to IDLE. out_valid/out_sum/out_cout/out_err SHALL be registered.
REQ-013 With a zero-delay adder, DATA and NULL SHALL each last exactly 3 cycles: 6 cycles per bit, 6*WIDTH cycles from accept to DONE entry.
REQ-014 in_valid SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.

Reset
REQ-015 With init high at a clk edge, the block SHALL enter IDLE and clear i, the counter, err, S, carry and the synchronizer flops; all outputs are 0 except fa_sum_ack = fa_carry_ack = 1; in_ready goes to 1 once fa_comp_s == 0.
REQ-016 init asserted mid-transaction (any state) SHALL abort at the next edge with no out_valid pulse; init has priority over all handshakes.

Verification
REQ-017 Directed scenarios, zero-delay behavioural NCL adder unless noted:
  - A=8'h35, B=8'h4A, cin=0 -> out_sum=8'h7F, out_cout=0, out_err=0, out_valid 48 cycles after accept.
  - A=8'hFF, B=8'h01, cin=0 -> out_sum=8'h00, out_cout=1; fa_cin carries 2'b10 on bits 1..7.
  - A=8'hFF, B=8'hFF, cin=1 -> out_sum=8'hFF, out_cout=1; out_ready held low 10 cycles -> outputs stable, in_ready=0 throughout.
  - Adder model stalls fa_comp low on bit 3 DATA -> DONE after TMO cycles, out_err=1, out_sum[7:3]=0.
  - Model forces fa_sum=2'b11 on bit 0 -> out_err=1, remaining bits still computed.
  - init pulsed during bit 5 NULL -> IDLE next cycle, no out_valid, next transaction A=1, B=1 -> out_sum=8'h02.
